// File: rtl/pipeline_regs_pkg.sv
// Shared types for the pipeline latch sequencer: FSM states, per-latch control
// bundle, register-index width and the branch flush mask helper.
package pipeline_regs_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned STAT_W = 32;

    typedef enum logic [2:0] {
        INIT,
        RUN,
        DWAIT,
        DRAIN,
        HALTED
    } hazard_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } latch_ctrl_t;

    // Bit 0 = FD, bit 1 = DE, bit 2 = EM; every latch up to the resolving stage is bubbled.
    function automatic logic [2:0] branch_flush_mask(input int unsigned stage);
        logic [2:0] m;
        m = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (i <= stage) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller <-> datapath bundle. PIPE_HAZARD_STATS_EN adds the
// stall_cyc / flush_cnt / lu_cnt counter outputs.
interface pipeline_hazard_ctrl_if;
    import pipeline_regs_pkg::*;

    logic              ihit;
    logic              dhit;
    logic              de_dmem_req;
    logic              em_dmem_req;
    logic              de_load;
    logic [REG_W-1:0]  de_rt;
    logic [REG_W-1:0]  fd_rs;
    logic [REG_W-1:0]  fd_rt;
    logic              fd_uses_rt;
    logic              br_taken;
    logic              mw_halt;

    logic              pc_en;
    logic              fd_en;
    logic              de_en;
    logic              em_en;
    logic              mw_en;
    logic              fd_flush;
    logic              de_flush;
    logic              em_flush;
    logic              halt_out;

`ifdef PIPE_HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_cyc;
    logic [STAT_W-1:0] flush_cnt;
    logic [STAT_W-1:0] lu_cnt;

    modport master (
        input  ihit, dhit, de_dmem_req, em_dmem_req, de_load, de_rt, fd_rs, fd_rt,
               fd_uses_rt, br_taken, mw_halt,
        output pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush,
               halt_out, stall_cyc, flush_cnt, lu_cnt
    );
    modport slave (
        output ihit, dhit, de_dmem_req, em_dmem_req, de_load, de_rt, fd_rs, fd_rt,
               fd_uses_rt, br_taken, mw_halt,
        input  pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush,
               halt_out, stall_cyc, flush_cnt, lu_cnt
    );
`else
    modport master (
        input  ihit, dhit, de_dmem_req, em_dmem_req, de_load, de_rt, fd_rs, fd_rt,
               fd_uses_rt, br_taken, mw_halt,
        output pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush,
               halt_out
    );
    modport slave (
        output ihit, dhit, de_dmem_req, em_dmem_req, de_load, de_rt, fd_rs, fd_rt,
               fd_uses_rt, br_taken, mw_halt,
        input  pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush,
               halt_out
    );
`endif

endinterface

// File: rtl/hazard_detect.sv
// Load-use detector: a load in DE whose destination feeds a source of the
// instruction in FD. Register 0 never stalls.
module hazard_detect
    import pipeline_regs_pkg::*;
(
    input  logic             de_load,
    input  logic [REG_W-1:0] de_rt,
    input  logic [REG_W-1:0] fd_rs,
    input  logic [REG_W-1:0] fd_rt,
    input  logic             fd_uses_rt,
    output logic             load_use
);

    always_comb begin
        load_use = de_load && (de_rt != '0) &&
                   ((de_rt == fd_rs) || (fd_uses_rt && (de_rt == fd_rt)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch sequencer: load-use bubbles, branch flushes, I/D memory waits
// and halt drain. Define PIPE_HAZARD_STATS_EN for saturating event counters.
module pipeline_hazard_ctrl
    import pipeline_regs_pkg::*;
#(
    parameter int unsigned BRANCH_STAGE = 2,
    parameter int unsigned HALT_DRAIN   = 4
) (
    input logic                    CLK,
    input logic                    RST,
    pipeline_hazard_ctrl_if.master hz
);

    localparam int unsigned      CNT_W      = $clog2(HALT_DRAIN) + 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(HALT_DRAIN - 1);
    localparam logic [2:0]       BR_FLUSH   = branch_flush_mask(BRANCH_STAGE);

    hazard_state_t    state, state_nxt;
    logic [CNT_W-1:0] drain_cnt;
    latch_ctrl_t      fd_c, de_c, em_c;
    logic             mw_en_c, pc_en_c, halt_c;
    logic             load_use, issue, br_evt, lu_evt;

    hazard_detect u_hazard_detect (
        .de_load    (hz.de_load),
        .de_rt      (hz.de_rt),
        .fd_rs      (hz.fd_rs),
        .fd_rt      (hz.fd_rt),
        .fd_uses_rt (hz.fd_uses_rt),
        .load_use   (load_use)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= INIT;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)       drain_cnt <= '0;
            else if (state == DRAIN) drain_cnt <= drain_cnt + CNT_W'(1);
        end
    end

    // RUN's normal issue priority (branch, load-use, I-miss) is shared with the DWAIT release cycle.
    assign issue = ((state == RUN) && !hz.mw_halt && !(hz.em_dmem_req && !hz.dhit)) ||
                   ((state == DWAIT) && hz.dhit);

    always_comb begin
        state_nxt = state;
        fd_c      = '0;
        de_c      = '0;
        em_c      = '0;
        mw_en_c   = 1'b0;
        pc_en_c   = 1'b0;
        halt_c    = 1'b0;
        br_evt    = 1'b0;
        lu_evt    = 1'b0;

        unique case (state)
            INIT: begin
                fd_c      = '{en: 1'b1, flush: 1'b1};
                de_c      = '{en: 1'b1, flush: 1'b1};
                em_c      = '{en: 1'b1, flush: 1'b1};
                mw_en_c   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (hz.mw_halt) begin
                    mw_en_c   = 1'b1;
                    state_nxt = DRAIN;
                end else if (hz.em_dmem_req && !hz.dhit) begin
                    state_nxt = DWAIT;
                end
            end
            DWAIT: begin
                if (hz.dhit) state_nxt = RUN;
            end
            DRAIN: begin
                mw_en_c = 1'b1;
                if (drain_cnt == DRAIN_LAST) state_nxt = HALTED;
            end
            HALTED: begin
                halt_c = 1'b1;
            end
            default: state_nxt = INIT;
        endcase

        if (issue) begin
            if (hz.br_taken) begin
                // Without ihit the redirect is held: the source latch is frozen and keeps br_taken up.
                if (hz.ihit) begin
                    pc_en_c = 1'b1;
                    fd_c    = '{en: 1'b1, flush: BR_FLUSH[0]};
                    de_c    = '{en: 1'b1, flush: BR_FLUSH[1]};
                    em_c    = '{en: 1'b1, flush: BR_FLUSH[2]};
                    mw_en_c = 1'b1;
                    br_evt  = 1'b1;
                end
            end else if (load_use) begin
                de_c    = '{en: 1'b1, flush: 1'b1};
                em_c.en = 1'b1;
                mw_en_c = 1'b1;
                lu_evt  = 1'b1;
            end else if (!hz.ihit) begin
                fd_c    = '{en: 1'b1, flush: 1'b1};
                de_c.en = 1'b1;
                em_c.en = 1'b1;
                mw_en_c = 1'b1;
            end else begin
                pc_en_c = 1'b1;
                fd_c.en = 1'b1;
                de_c.en = 1'b1;
                em_c.en = 1'b1;
                mw_en_c = 1'b1;
            end
        end
    end

    assign hz.pc_en    = pc_en_c;
    assign hz.fd_en    = fd_c.en;
    assign hz.fd_flush = fd_c.flush;
    assign hz.de_en    = de_c.en;
    assign hz.de_flush = de_c.flush;
    assign hz.em_en    = em_c.en;
    assign hz.em_flush = em_c.flush;
    assign hz.mw_en    = mw_en_c;
    assign hz.halt_out = halt_c;

    // The D-cache freeze keys on the request already in EM; the DE-side request is not needed.
    logic unused_de_dmem_req;
    assign unused_de_dmem_req = hz.de_dmem_req;

`ifdef PIPE_HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_q, flush_q, lu_q;
    logic              stall_evt;

    assign stall_evt = ((state == RUN) || (state == DWAIT)) && !pc_en_c;

    always_ff @(posedge CLK) begin
        if (RST || (state == INIT)) begin
            stall_q <= '0;
            flush_q <= '0;
            lu_q    <= '0;
        end else begin
            if (stall_evt && (stall_q != '1)) stall_q <= stall_q + STAT_W'(1);
            if (br_evt    && (flush_q != '1)) flush_q <= flush_q + STAT_W'(1);
            if (lu_evt    && (lu_q    != '1)) lu_q    <= lu_q + STAT_W'(1);
        end
    end

    assign hz.stall_cyc = stall_q;
    assign hz.flush_cnt = flush_q;
    assign hz.lu_cnt    = lu_q;
`else
    logic unused_evt;
    assign unused_evt = br_evt ^ lu_evt;
`endif

endmodule
